// File: rtl/i2c_codec_target_if.sv
// rtl/i2c_codec_target_if.sv - register-file read port and frame-commit outputs of the codec target
interface i2c_codec_target_if;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       bad_addr;
  logic [7:0] frame_count;

  modport slave (
    input  rd_addr,
    output rd_data, wr_valid, wr_addr, wr_data, bad_addr, frame_count
  );

  modport master (
    output rd_addr,
    input  rd_data, wr_valid, wr_addr, wr_data, bad_addr, frame_count
  );
endinterface

// File: rtl/i2c_codec_target.sv
// rtl/i2c_codec_target.sv - write-only I2C target standing in for the audio codec control port
// Decodes 3-byte frames {dev,w} {addr,d8} {d7..d0} into a small register file.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 16,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               I2C_SCLK,
  inout  wire                I2C_SDAT,
  i2c_codec_target_if.slave  bus
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_EXTRA, S_IGNORE
  } state_t;

  state_t      r_state;
  logic [1:0]  r_scl_sync;
  logic [1:0]  r_sda_sync;
  logic        r_scl_prev;
  logic        r_sda_prev;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic [6:0]  r_addr;
  logic [8:0]  r_data;
  logic        r_sda_drv;
  logic [8:0]  r_regs [NUM_REGS];
  logic        r_wr_valid;
  logic [6:0]  r_wr_addr;
  logic [8:0]  r_wr_data;
  logic        r_bad_addr;
  logic [7:0]  r_frame_count;

  state_t      w_state_nx;
  logic        w_drv_nx;
  logic        w_commit;
  logic        w_shift_en;
  logic        w_bit_clr;
  logic        w_latch1;
  logic        w_latch2;

  wire         w_scl      = r_scl_sync[1];
  wire         w_sda      = r_sda_sync[1];
  wire         w_scl_rise = w_scl & ~r_scl_prev;
  wire         w_scl_fall = ~w_scl & r_scl_prev;
  wire         w_start    = w_scl & r_sda_prev & ~w_sda;
  wire         w_stop     = w_scl & ~r_sda_prev & w_sda;
  wire [7:0]   w_byte     = {r_shift, w_sda};

  // Open-drain: only ever pull low, the bus pull-up supplies the high level.
  assign I2C_SDAT = r_sda_drv ? 1'b0 : 1'bz;

  always_comb begin
    w_state_nx = r_state;
    w_drv_nx   = r_sda_drv;
    w_commit   = 1'b0;
    w_shift_en = 1'b0;
    w_bit_clr  = 1'b0;
    w_latch1   = 1'b0;
    w_latch2   = 1'b0;
    if (w_stop) begin
      w_state_nx = S_IDLE;
      w_drv_nx   = 1'b0;
      w_bit_clr  = 1'b1;
    end else if (w_start) begin
      w_state_nx = S_ADDR;
      w_drv_nx   = 1'b0;
      w_bit_clr  = 1'b1;
    end else begin
      case (r_state)
        S_ADDR, S_BYTE1, S_BYTE2, S_EXTRA: begin
          if (w_scl_rise) begin
            w_shift_en = 1'b1;
            if (r_bit_cnt == 3'd7) begin
              case (r_state)
                S_ADDR:  w_state_nx = (w_byte == {DEV_ADDR, 1'b0}) ? S_ACK_A : S_IGNORE;
                S_BYTE1: begin w_latch1 = 1'b1; w_state_nx = S_ACK_1; end
                S_BYTE2: begin w_latch2 = 1'b1; w_state_nx = S_ACK_2; end
                default: w_state_nx = S_IGNORE;
              endcase
            end
          end
        end
        // First SCL fall after bit 8 starts the ACK, the next one ends it.
        S_ACK_A, S_ACK_1, S_ACK_2: begin
          if (w_scl_fall) begin
            if (!r_sda_drv) begin
              w_drv_nx = 1'b1;
            end else begin
              w_drv_nx = 1'b0;
              case (r_state)
                S_ACK_A: w_state_nx = S_BYTE1;
                S_ACK_1: w_state_nx = S_BYTE2;
                default: begin w_state_nx = S_EXTRA; w_commit = 1'b1; end
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_scl_sync    <= '0;
      r_sda_sync    <= '0;
      r_scl_prev    <= 1'b0;
      r_sda_prev    <= 1'b0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_sda_drv     <= 1'b0;
      r_wr_valid    <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_bad_addr    <= 1'b0;
      r_frame_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_scl_sync <= {r_scl_sync[0], I2C_SCLK};
      r_sda_sync <= {r_sda_sync[0], I2C_SDAT};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
      r_state    <= w_state_nx;
      r_sda_drv  <= w_drv_nx;
      r_wr_valid <= w_commit;
      if (w_bit_clr)       r_bit_cnt <= '0;
      else if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_shift_en) r_shift <= w_byte[6:0];
      if (w_latch1) begin
        r_addr    <= w_byte[7:1];
        r_data[8] <= w_byte[0];
      end
      if (w_latch2) r_data[7:0] <= w_byte;
      if (w_commit) begin
        r_wr_addr     <= r_addr;
        r_wr_data     <= r_data;
        r_frame_count <= r_frame_count + 8'd1;
        if (r_addr == RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (int'(r_addr) < NUM_REGS) begin
          r_regs[r_addr[AW-1:0]] <= r_data;
        end else begin
          r_bad_addr <= 1'b1;
        end
      end
    end
  end

  assign bus.rd_data     = (int'(bus.rd_addr) < NUM_REGS) ? r_regs[bus.rd_addr[AW-1:0]] : '0;
  assign bus.wr_valid    = r_wr_valid;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.bad_addr    = r_bad_addr;
  assign bus.frame_count = r_frame_count;

endmodule
